// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALT control, stall, redirect.
// Optional return-address stack enabled with `define PC_RAS_EN.
module pc_gen #(
    parameter int unsigned           PC_W      = 32,
    parameter int unsigned           INC       = 4,
    parameter logic [PC_W-1:0]       RESET_VEC = '0,
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            fetch_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            halted_o,
    output logic            ras_full_o,
    output logic            ras_empty_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [PC_W-1:0] STEP  = PC_W'(INC);
    localparam logic [PC_W-1:0] ALIGN = ~(PC_W'(INC - 1));

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;
    logic            halted_q;

    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] seq_pc;
    logic            accept;
    logic            adv;
    logic            pop;
    logic [PC_W-1:0] ras_top;

    assign tgt    = redirect_pc_i & ALIGN;
    assign seq_pc = pc_q + STEP;
    assign accept = fetch_ready_i & ~stall_i & valid_q;
    // halt suppresses any same-cycle advance, including a RAS pop
    assign adv    = (state_q == RUN) & ~redirect_valid_i & accept & ~halt_i;

`ifdef PC_RAS_EN
    localparam int unsigned AW = $clog2(RAS_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(RAS_DEPTH);

    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [AW-1:0]   sp_q;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic            full_q;
    logic            empty_q;
    logic            push;

    assign push    = redirect_valid_i & call_i & (state_q != BOOT);
    assign pop     = adv & ret_i & ~empty_q;
    assign ras_top = ras_q[sp_q - 1'b1];

    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // circular storage: a push when full overwrites the oldest slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
            sp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                ras_q[sp_q] <= seq_pc;
                sp_q        <= sp_q + 1'b1;
            end else if (pop) begin
                sp_q <= sp_q - 1'b1;
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FULL_CNT);
            empty_q <= (cnt_d == '0);
        end
    end

    assign ras_full_o  = full_q;
    assign ras_empty_o = empty_q;
`else
    logic unused_ras;

    assign unused_ras  = ^{call_i, ret_i};
    assign pop         = 1'b0;
    assign ras_top     = '0;
    assign ras_full_o  = 1'b0;
    assign ras_empty_o = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VEC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (redirect_valid_i) pc_q <= tgt;
                    else if (pop)         pc_q <= ras_top;
                    else if (adv)         pc_q <= seq_pc;
                    if (halt_i) begin
                        state_q  <= HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    if (redirect_valid_i) pc_q <= tgt;
                    if (!halt_i) begin
                        state_q  <= RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= BOOT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign halted_o   = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, advance, stall, redirect, wrap, halt, RAS.
// RAS checks run when PC_RAS_EN is defined, call/ret-ignored checks otherwise.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        call_i;
    logic        ret_i;
    logic        fetch_ready_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        halted_o;
    logic        ras_full_o;
    logic        ras_empty_o;

    logic [7:0]  s_pc;
    logic        s_valid;
    logic        s_halted;
    logic        s_full;
    logic        s_empty;

    int total = 0;
    int bad   = 0;

    pc_gen #(
        .PC_W(32), .INC(4), .RESET_VEC(32'h100), .RAS_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .halt_i(halt_i), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .call_i(call_i), .ret_i(ret_i),
        .fetch_ready_i(fetch_ready_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .halted_o(halted_o),
        .ras_full_o(ras_full_o), .ras_empty_o(ras_empty_o)
    );

    pc_gen #(
        .PC_W(8), .INC(4), .RESET_VEC(8'hF0), .RAS_DEPTH(2)
    ) dut8 (
        .clk(clk), .rst(rst),
        .halt_i(1'b0), .stall_i(1'b0),
        .redirect_valid_i(1'b0), .redirect_pc_i(8'h00),
        .call_i(1'b0), .ret_i(1'b0),
        .fetch_ready_i(1'b1),
        .pc_o(s_pc), .pc_valid_o(s_valid), .halted_o(s_halted),
        .ras_full_o(s_full), .ras_empty_o(s_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc,
                          input logic v, input logic h);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, v});
        chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, h});
    endtask

    initial begin
        rst = 1'b1;
        halt_i = 1'b0;
        stall_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        call_i = 1'b0;
        ret_i = 1'b0;
        fetch_ready_i = 1'b1;
        step();
        step();
        chk_pc("reset", 32'h100, 1'b0, 1'b0);
        chk("reset.empty", {31'd0, ras_empty_o}, 32'd1);
        chk("reset.full", {31'd0, ras_full_o}, 32'd0);
        chk("reset8.pc", {24'd0, s_pc}, 32'hF0);
        rst = 1'b0;

        step();
        chk_pc("boot", 32'h100, 1'b1, 1'b0);
        chk("boot8", {24'd0, s_pc}, 32'hF0);
        step();
        chk_pc("adv1", 32'h104, 1'b1, 1'b0);
        step();
        step();
        chk("adv8", {24'd0, s_pc}, 32'hFC);
        step();
        chk_pc("adv4", 32'h110, 1'b1, 1'b0);
        chk("wrap8", {24'd0, s_pc}, 32'h00);
        chk("wrap8.valid", {31'd0, s_valid}, 32'd1);

        // asynchronous reset pulse mid-cycle
        rst = 1'b1;
        #1;
        chk_pc("midrst", 32'h100, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step();
        chk_pc("rerun0", 32'h100, 1'b1, 1'b0);
        step();
        chk_pc("rerun1", 32'h104, 1'b1, 1'b0);
        step();
        chk_pc("rerun2", 32'h108, 1'b1, 1'b0);
        step();
        chk_pc("rerun3", 32'h10C, 1'b1, 1'b0);

        stall_i = 1'b1;
        step();
        step();
        step();
        chk_pc("stall", 32'h10C, 1'b1, 1'b0);
        stall_i = 1'b0;
        fetch_ready_i = 1'b0;
        step();
        chk_pc("notready", 32'h10C, 1'b1, 1'b0);
        fetch_ready_i = 1'b1;
        step();
        chk_pc("release", 32'h110, 1'b1, 1'b0);

        stall_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h2003;
        step();
        chk_pc("redir", 32'h2000, 1'b1, 1'b0);
        stall_i = 1'b0;
        redirect_valid_i = 1'b0;
        step();
        chk_pc("redir+1", 32'h2004, 1'b1, 1'b0);

        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_valid_i = 1'b0;
        chk_pc("to40", 32'h40, 1'b1, 1'b0);
        halt_i = 1'b1;
        step();
        chk_pc("halt", 32'h40, 1'b0, 1'b1);
        step();
        chk_pc("halt2", 32'h40, 1'b0, 1'b1);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h80;
        step();
        redirect_valid_i = 1'b0;
        chk_pc("haltredir", 32'h80, 1'b0, 1'b1);
        halt_i = 1'b0;
        step();
        chk_pc("unhalt", 32'h80, 1'b1, 1'b0);
        step();
        chk_pc("unhalt+1", 32'h84, 1'b1, 1'b0);

`ifdef PC_RAS_EN
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h10;
        step();
        call_i = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        chk("call1.empty", {31'd0, ras_empty_o}, 32'd0);
        call_i = 1'b0;
        redirect_pc_i = 32'h20;
        step();
        call_i = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        chk("call2.full", {31'd0, ras_full_o}, 32'd1);
        call_i = 1'b0;
        redirect_pc_i = 32'h30;
        step();
        call_i = 1'b1;
        redirect_pc_i = 32'h300;
        step();
        chk_pc("call3", 32'h300, 1'b1, 1'b0);
        chk("call3.full", {31'd0, ras_full_o}, 32'd1);
        call_i = 1'b0;
        redirect_valid_i = 1'b0;
        ret_i = 1'b1;
        step();
        chk_pc("ret1", 32'h34, 1'b1, 1'b0);
        chk("ret1.full", {31'd0, ras_full_o}, 32'd0);
        step();
        chk_pc("ret2", 32'h24, 1'b1, 1'b0);
        chk("ret2.empty", {31'd0, ras_empty_o}, 32'd1);
        step();
        chk_pc("ret3", 32'h28, 1'b1, 1'b0);
        chk("ret3.empty", {31'd0, ras_empty_o}, 32'd1);
        ret_i = 1'b0;
`else
        redirect_valid_i = 1'b1;
        call_i = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        chk_pc("nocall", 32'h200, 1'b1, 1'b0);
        chk("nocall.empty", {31'd0, ras_empty_o}, 32'd1);
        chk("nocall.full", {31'd0, ras_full_o}, 32'd0);
        redirect_valid_i = 1'b0;
        call_i = 1'b0;
        ret_i = 1'b1;
        step();
        chk_pc("noret", 32'h204, 1'b1, 1'b0);
        step();
        chk_pc("noret2", 32'h208, 1'b1, 1'b0);
        chk("noret.empty", {31'd0, ras_empty_o}, 32'd1);
        ret_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
